// File: rtl/ctrl_pkg.sv
// Shared types and constants for the multi-cycle RV32I control FSM.
// Contents: state enum, opcode values, ALU-op codes, datapath mux selects and
// an opcode dispatch helper used by the DECODE step.
package ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    EXEC_R,
    EXEC_I,
    WB_ALU,
    MEM_ADDR,
    MEM_RD,
    WB_MEM,
    MEM_WR,
    BRANCH,
    JAL,
    TRAP
  } state_t;

  // Opcodes (instr[6:0])
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] FUNCT3_BEQ = 3'b000;

  // ALU op for the ALU-control decoder
  localparam logic [1:0] ALUOP_ADD = 2'b00;
  localparam logic [1:0] ALUOP_SUB = 2'b01;
  localparam logic [1:0] ALUOP_R   = 2'b10;
  localparam logic [1:0] ALUOP_I   = 2'b11;

  // Datapath mux selects
  localparam logic       PCSRC_ALU    = 1'b0;
  localparam logic       PCSRC_ALUOUT = 1'b1;
  localparam logic       IORD_PC      = 1'b0;
  localparam logic       IORD_ALUOUT  = 1'b1;
  localparam logic [1:0] WB_ALUOUT    = 2'b00;
  localparam logic [1:0] WB_MDR       = 2'b01;
  localparam logic [1:0] WB_PC4       = 2'b10;
  localparam logic [1:0] SRCA_PC      = 2'b00;
  localparam logic [1:0] SRCA_RS1     = 2'b01;
  localparam logic [1:0] SRCA_OLDPC   = 2'b10;
  localparam logic [1:0] SRCB_RS2     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;

  // First execute state for an opcode; TRAP marks an unsupported opcode.
  function automatic state_t dispatch(input logic [6:0] opcode);
    case (opcode)
      OP_R:               return EXEC_R;
      OP_IMM:             return EXEC_I;
      OP_LOAD, OP_STORE:  return MEM_ADDR;
      OP_BRANCH:          return BRANCH;
      OP_JAL:             return JAL;
      default:            return TRAP;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multi-cycle RV32I core. Sequences the shared ALU,
// the shared memory port and the register file through fetch, decode,
// execute, memory and writeback steps.
//
// Optional feature: define RETIRE_CNT_EN to add the CNT_W-bit retired
// instruction counter and its instret output.
//
// Ports:
//   clk, reset           clock, asynchronous active-high reset
//   instr                instruction register (valid from DECODE onward)
//   mem_ready            memory port completion
//   zero                 ALU zero flag
//   pc_write, pc_src     PC load enable and source select
//   ir_write             instruction register load
//   mem_read, mem_write  memory requests
//   i_or_d               memory address select
//   reg_write, wb_sel    register file write enable and data select
//   alu_src_a/b, alu_op  ALU operand selects and operation class
//   illegal              sticky illegal-opcode flag
//   instret              retired count (RETIRE_CNT_EN only)
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter bit TRAP_ON_ILLEGAL = 1'b1
`ifdef RETIRE_CNT_EN
  ,
  parameter int unsigned CNT_W = 32
`endif
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        mem_ready,
  input  logic        zero,
  output logic        pc_write,
  output logic        pc_src,
  output logic        ir_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        i_or_d,
  output logic        reg_write,
  output logic [1:0]  wb_sel,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  alu_op,
  output logic        illegal
`ifdef RETIRE_CNT_EN
  ,
  output logic [CNT_W-1:0] instret
`endif
);

  state_t state_q, state_d;
  logic   illegal_q;
  logic   is_illegal;
  logic   retire;

  // Only opcode, funct3 and the load/store bit are decoded here.
  logic unused_instr;
  assign unused_instr = ^{instr[31:15], instr[11:7]};

  assign is_illegal = (state_q == DECODE) && (dispatch(instr[6:0]) == TRAP);

  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:    if (mem_ready) state_d = DECODE;
      DECODE: begin
        state_d = dispatch(instr[6:0]);
        if (state_d == TRAP && !TRAP_ON_ILLEGAL) state_d = FETCH;
      end
      EXEC_R:   state_d = WB_ALU;
      EXEC_I:   state_d = WB_ALU;
      WB_ALU:   state_d = FETCH;
      MEM_ADDR: state_d = instr[5] ? MEM_WR : MEM_RD;
      MEM_RD:   if (mem_ready) state_d = WB_MEM;
      WB_MEM:   state_d = FETCH;
      MEM_WR:   if (mem_ready) state_d = FETCH;
      BRANCH:   state_d = FETCH;
      JAL:      state_d = FETCH;
      TRAP:     state_d = TRAP;
      default:  state_d = FETCH;
    endcase
  end

  // Staying in FETCH while waiting on memory is not a retire.
  assign retire = (state_d == FETCH) && (state_q != FETCH) && (state_q != TRAP);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (is_illegal) illegal_q <= 1'b1;
    end
  end

`ifdef RETIRE_CNT_EN
  logic [CNT_W-1:0] instret_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instret_q <= '0;
    end else if (retire) begin
      instret_q <= instret_q + CNT_W'(1);
    end
  end

  assign instret = instret_q;
`else
  logic unused_retire;
  assign unused_retire = retire;
`endif

  // Outputs decoded from state; pc_write/ir_write in FETCH and pc_write in
  // BRANCH additionally follow mem_ready / zero.
  logic pc_write_s, ir_write_s, mem_read_s, mem_write_s, reg_write_s;

  always_comb begin
    pc_write_s  = 1'b0;
    pc_src      = PCSRC_ALU;
    ir_write_s  = 1'b0;
    mem_read_s  = 1'b0;
    mem_write_s = 1'b0;
    i_or_d      = IORD_PC;
    reg_write_s = 1'b0;
    wb_sel      = WB_ALUOUT;
    alu_src_a   = SRCA_PC;
    alu_src_b   = SRCB_RS2;
    alu_op      = ALUOP_ADD;
    case (state_q)
      FETCH: begin
        mem_read_s = 1'b1;
        alu_src_b  = SRCB_FOUR;
        ir_write_s = mem_ready;
        pc_write_s = mem_ready;
      end
      DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
      end
      EXEC_R: begin
        alu_src_a = SRCA_RS1;
        alu_op    = ALUOP_R;
      end
      EXEC_I: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_I;
      end
      WB_ALU:   reg_write_s = 1'b1;
      MEM_ADDR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
      end
      MEM_RD: begin
        mem_read_s = 1'b1;
        i_or_d     = IORD_ALUOUT;
      end
      WB_MEM: begin
        reg_write_s = 1'b1;
        wb_sel      = WB_MDR;
      end
      MEM_WR: begin
        mem_write_s = 1'b1;
        i_or_d      = IORD_ALUOUT;
      end
      BRANCH: begin
        alu_src_a  = SRCA_RS1;
        alu_op     = ALUOP_SUB;
        pc_src     = PCSRC_ALUOUT;
        pc_write_s = zero && (instr[14:12] == FUNCT3_BEQ);
      end
      JAL: begin
        reg_write_s = 1'b1;
        wb_sel      = WB_PC4;
        pc_write_s  = 1'b1;
        pc_src      = PCSRC_ALUOUT;
      end
      default: ;
    endcase
  end

  // Reset kills every enable immediately, including an in-flight access.
  assign pc_write  = pc_write_s  && !reset;
  assign ir_write  = ir_write_s  && !reset;
  assign mem_read  = mem_read_s  && !reset;
  assign mem_write = mem_write_s && !reset;
  assign reg_write = reg_write_s && !reset;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: expected output vectors are queued as
// each cycle's stimulus is applied and compared when the cycle is sampled.
module tb_multicycle_ctrl;

  logic        clk;
  logic        reset;
  logic [31:0] instr;
  logic        mem_ready;
  logic        zero;
  logic        pc_write, pc_src, ir_write, mem_read, mem_write, i_or_d, reg_write;
  logic [1:0]  wb_sel, alu_src_a, alu_src_b, alu_op;
  logic        illegal;
`ifdef RETIRE_CNT_EN
  logic [3:0]  instret;
`endif

  multicycle_ctrl #(
    .TRAP_ON_ILLEGAL(1'b1)
`ifdef RETIRE_CNT_EN
    ,
    .CNT_W(4)
`endif
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .instr     (instr),
    .mem_ready (mem_ready),
    .zero      (zero),
    .pc_write  (pc_write),
    .pc_src    (pc_src),
    .ir_write  (ir_write),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .i_or_d    (i_or_d),
    .reg_write (reg_write),
    .wb_sel    (wb_sel),
    .alu_src_a (alu_src_a),
    .alu_src_b (alu_src_b),
    .alu_op    (alu_op),
    .illegal   (illegal)
`ifdef RETIRE_CNT_EN
    ,
    .instret   (instret)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] obs;
  assign obs = {pc_write, pc_src, ir_write, mem_read, mem_write, i_or_d, reg_write,
                wb_sel, alu_src_a, alu_src_b, alu_op, illegal};

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  logic [15:0] exp_q[$];

  function automatic logic [15:0] ov(input logic pcw, input logic pcs, input logic irw,
                                     input logic mr, input logic mw, input logic iod,
                                     input logic rw, input logic [1:0] wb,
                                     input logic [1:0] a, input logic [1:0] b,
                                     input logic [1:0] op, input logic ill);
    return {pcw, pcs, irw, mr, mw, iod, rw, wb, a, b, op, ill};
  endfunction

  // Expected vectors per state
  function automatic logic [15:0] e_fetch(input logic rdy);
    return ov(rdy, 0, rdy, 1, 0, 0, 0, 2'b00, 2'b00, 2'b01, 2'b00, 0);
  endfunction
  function automatic logic [15:0] e_branch(input logic pcw);
    return ov(pcw, 1, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b00, 2'b01, 0);
  endfunction
  localparam logic [15:0] E_DECODE = {7'b0000000, 2'b00, 2'b10, 2'b10, 2'b00, 1'b0};
  localparam logic [15:0] E_EXEC_R = {7'b0000000, 2'b00, 2'b01, 2'b00, 2'b10, 1'b0};
  localparam logic [15:0] E_EXEC_I = {7'b0000000, 2'b00, 2'b01, 2'b10, 2'b11, 1'b0};
  localparam logic [15:0] E_WB_ALU = {7'b0000001, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
  localparam logic [15:0] E_MADDR  = {7'b0000000, 2'b00, 2'b01, 2'b10, 2'b00, 1'b0};
  localparam logic [15:0] E_MEM_RD = {7'b0001010, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
  localparam logic [15:0] E_WB_MEM = {7'b0000001, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0};
  localparam logic [15:0] E_MEM_WR = {7'b0000110, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
  localparam logic [15:0] E_JAL    = {7'b1100001, 2'b10, 2'b00, 2'b00, 2'b00, 1'b0};
  localparam logic [15:0] E_TRAP   = {7'b0000000, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1};
  // In reset: FETCH selects, every enable forced low, illegal cleared
  localparam logic [15:0] E_RESET  = {7'b0000000, 2'b00, 2'b00, 2'b01, 2'b00, 1'b0};

  localparam logic [31:0] I_ADDI = 32'h0050_0093;
  localparam logic [31:0] I_LW   = 32'h0000_A103;
  localparam logic [31:0] I_SW   = 32'h0020_A023;
  localparam logic [31:0] I_ADD  = 32'h0020_81B3;
  localparam logic [31:0] I_BEQ  = 32'h0020_8463;
  localparam logic [31:0] I_BNE  = 32'h0020_9463;
  localparam logic [31:0] I_JAL  = 32'h0080_00EF;
  localparam logic [31:0] I_BAD  = 32'h0000_007F;

  task automatic check_now(input string tag);
    logic [15:0] exp;
    exp = exp_q.pop_front();
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // One clock cycle: drive inputs, queue expectation, sample, then clock.
  task automatic cyc(input string tag, input logic [15:0] exp, input logic rdy,
                     input logic z);
    mem_ready = rdy;
    zero      = z;
    exp_q.push_back(exp);
    #1;
    check_now(tag);
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset(input string tag);
    reset = 1'b1;
    exp_q.push_back(E_RESET);
    #1;
    check_now(tag);
    #1;
    reset = 1'b0;
    #1;
  endtask

`ifdef RETIRE_CNT_EN
  task automatic check_cnt(input string tag, input logic [3:0] exp);
    n_checks++;
    assert (instret === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, instret, exp);
  endtask
`endif

  initial begin
    reset     = 1'b1;
    instr     = 32'h0;
    mem_ready = 1'b0;
    zero      = 1'b0;
    #2;
    exp_q.push_back(E_RESET);
    check_now("reset_state");
    #10;
    reset = 1'b0;

    // addi: fetch wait, then FETCH, DECODE, EXEC_I, WB_ALU
    instr = I_ADDI;
    cyc("addi_fetch_wait", e_fetch(1'b0), 1'b0, 1'b0);
    cyc("addi_fetch", e_fetch(1'b1), 1'b1, 1'b0);
    cyc("addi_decode", E_DECODE, 1'b0, 1'b0);
    cyc("addi_exec_i", E_EXEC_I, 1'b0, 1'b0);
    cyc("addi_wb", E_WB_ALU, 1'b0, 1'b0);

    // lw with three wait cycles in MEM_RD
    instr = I_LW;
    cyc("lw_fetch", e_fetch(1'b1), 1'b1, 1'b0);
    cyc("lw_decode", E_DECODE, 1'b1, 1'b0);
    cyc("lw_addr", E_MADDR, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cyc("lw_rd_wait", E_MEM_RD, 1'b0, 1'b0);
    cyc("lw_rd_done", E_MEM_RD, 1'b1, 1'b0);
    cyc("lw_wb", E_WB_MEM, 1'b0, 1'b0);

    // sw with one wait cycle
    instr = I_SW;
    cyc("sw_fetch", e_fetch(1'b1), 1'b1, 1'b0);
    cyc("sw_decode", E_DECODE, 1'b0, 1'b0);
    cyc("sw_addr", E_MADDR, 1'b0, 1'b0);
    cyc("sw_wr_wait", E_MEM_WR, 1'b0, 1'b0);
    cyc("sw_wr_done", E_MEM_WR, 1'b1, 1'b0);

    // add (R-type); stray mem_ready / zero must be ignored
    instr = I_ADD;
    cyc("add_fetch", e_fetch(1'b1), 1'b1, 1'b0);
    cyc("add_decode", E_DECODE, 1'b1, 1'b1);
    cyc("add_exec_r", E_EXEC_R, 1'b1, 1'b1);
    cyc("add_wb", E_WB_ALU, 1'b1, 1'b1);

    // beq taken, beq not taken, bne with zero=1 never writes PC
    instr = I_BEQ;
    cyc("beq_t_fetch", e_fetch(1'b1), 1'b1, 1'b0);
    cyc("beq_t_decode", E_DECODE, 1'b0, 1'b0);
    cyc("beq_t_branch", e_branch(1'b1), 1'b0, 1'b1);
    cyc("beq_n_fetch", e_fetch(1'b1), 1'b1, 1'b0);
    cyc("beq_n_decode", E_DECODE, 1'b0, 1'b0);
    cyc("beq_n_branch", e_branch(1'b0), 1'b0, 1'b0);
    instr = I_BNE;
    cyc("bne_fetch", e_fetch(1'b1), 1'b1, 1'b0);
    cyc("bne_decode", E_DECODE, 1'b0, 1'b0);
    cyc("bne_branch", e_branch(1'b0), 1'b0, 1'b1);

    // jal
    instr = I_JAL;
    cyc("jal_fetch", e_fetch(1'b1), 1'b1, 1'b0);
    cyc("jal_decode", E_DECODE, 1'b0, 1'b0);
    cyc("jal_exec", E_JAL, 1'b0, 1'b0);
    cyc("jal_back_fetch", e_fetch(1'b0), 1'b0, 1'b0);

    // Reset while a store is waiting on memory
    instr = I_SW;
    cyc("sw2_fetch", e_fetch(1'b1), 1'b1, 1'b0);
    cyc("sw2_decode", E_DECODE, 1'b0, 1'b0);
    cyc("sw2_addr", E_MADDR, 1'b0, 1'b0);
    mem_ready = 1'b0;
    exp_q.push_back(E_MEM_WR);
    #1;
    check_now("sw2_wr_active");
    pulse_reset("sw2_reset_drop");
    cyc("sw2_resume_fetch", e_fetch(1'b0), 1'b0, 1'b0);

    // Illegal opcode parks in TRAP until reset
    instr = I_BAD;
    cyc("bad_fetch", e_fetch(1'b1), 1'b1, 1'b0);
    cyc("bad_decode", E_DECODE, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc("bad_trap", E_TRAP, 1'b1, 1'b1);
    pulse_reset("bad_reset");
    cyc("bad_after_reset", e_fetch(1'b0), 1'b0, 1'b0);

`ifdef RETIRE_CNT_EN
    pulse_reset("cnt_reset");
    check_cnt("cnt_zero", 4'd0);
    instr = I_ADDI;
    for (int k = 0; k < 17; k++) begin
      cyc("cnt_fetch", e_fetch(1'b1), 1'b1, 1'b0);
      cyc("cnt_decode", E_DECODE, 1'b0, 1'b0);
      cyc("cnt_exec_i", E_EXEC_I, 1'b0, 1'b0);
      cyc("cnt_wb", E_WB_ALU, 1'b0, 1'b0);
      if (k == 0) check_cnt("cnt_first", 4'd1);
    end
    check_cnt("cnt_wrap", 4'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
